// File: rtl/tx_rs_enc_lfsr_if.sv
// Handshake and symbol bus between the frame builder (master) and the RS encoder (slave).
// The frame builder drives the i_* signals and the encoder drives the o_* signals.
interface tx_rs_enc_lfsr_if;
  logic       i_rs_en;
  logic       i_sof;
  logic [7:0] i_data;
  logic       i_valid;
  logic       i_last;
  logic       o_ready;
  logic       o_sof;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_par;
  logic       o_last;
  logic       o_ovf;

  modport master (
    output i_rs_en, i_sof, i_data, i_valid, i_last,
    input  o_ready, o_sof, o_data, o_valid, o_par, o_last, o_ovf
  );

  modport slave (
    input  i_rs_en, i_sof, i_data, i_valid, i_last,
    output o_ready, o_sof, o_data, o_valid, o_par, o_last, o_ovf
  );
endinterface

// File: rtl/tx_rs_enc_lfsr.sv
// Systematic RS(K_DATA+N_PARITY, K_DATA) LFSR encoder over GF(2^8) with runtime bypass; latency 1.
// o_ready drops for the N_PARITY parity cycles; input offered then is dropped and flagged on sticky o_ovf.
module tx_rs_enc_lfsr #(
  parameter int         N_PARITY  = 16,
  parameter int         K_DATA    = 239,
  parameter logic [8:0] PRIM_POLY = 9'h11D,
  parameter int         FCR       = 0
) (
  input logic            i_clk,
  input logic            i_rst_n,
  tx_rs_enc_lfsr_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;

  localparam int CW = $clog2(K_DATA + 1);
  localparam int PW = $clog2(N_PARITY);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = aa[7] ? ((aa << 1) ^ PRIM_POLY[7:0]) : (aa << 1);
    end
    return acc;
  endfunction

  function automatic logic [7:0] gf_alpha_pow(input int e);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < e; i++) r = gf_mul(r, 8'h02);
    return r;
  endfunction

  // Multiply out (x + a^(FCR+i)) one root at a time; the leading 1 is implicit in the LFSR.
  function automatic logic [N_PARITY-1:0][7:0] gen_poly();
    logic [N_PARITY:0][7:0] g;
    logic [7:0]             root;
    g    = '0;
    g[0] = 8'h01;
    root = gf_alpha_pow(FCR);
    for (int i = 0; i < N_PARITY; i++) begin
      for (int j = N_PARITY; j > 0; j--) g[j] = g[j-1] ^ gf_mul(g[j], root);
      g[0] = gf_mul(g[0], root);
      root = gf_mul(root, 8'h02);
    end
    return g[N_PARITY-1:0];
  endfunction

  localparam logic [N_PARITY-1:0][7:0] G = gen_poly();

  logic [1:0]                state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [PW-1:0]             pcnt_q, pcnt_d;
  logic [N_PARITY-1:0][7:0]  par_q, par_d;
  logic [N_PARITY-1:0][7:0]  par_src, lfsr_nxt;
  logic [7:0]                fb;
  logic                      accept;
  logic                      ready_q, ready_d;
  logic                      sof_q, sof_d;
  logic [7:0]                data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      parf_q, parf_d;
  logic                      last_q, last_d;
  logic                      ovf_q, ovf_d;

  assign accept = bus.i_valid & ready_q;

  // A new codeword starts from an all-zero remainder regardless of what par_q holds.
  always_comb begin
    par_src  = (state_q == S_IDLE) ? '0 : par_q;
    fb       = bus.i_data ^ par_src[N_PARITY-1];
    lfsr_nxt = '0;
    lfsr_nxt[0] = gf_mul(fb, G[0]);
    for (int i = 1; i < N_PARITY; i++) lfsr_nxt[i] = par_src[i-1] ^ gf_mul(fb, G[i]);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    par_d   = par_q;
    sof_d   = 1'b0;
    data_d  = 8'h00;
    valid_d = 1'b0;
    parf_d  = 1'b0;
    last_d  = 1'b0;
    ovf_d   = ovf_q | (bus.i_valid & ~ready_q);

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          valid_d = 1'b1;
          data_d  = bus.i_data;
          sof_d   = bus.i_sof;
          if (bus.i_rs_en) begin
            par_d = lfsr_nxt;
            if (bus.i_last || (K_DATA == 1)) begin
              state_d = S_PARITY;
              cnt_d   = '0;
            end else begin
              state_d = S_DATA;
              cnt_d   = CW'(1);
            end
          end else begin
            last_d = bus.i_last;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          valid_d = 1'b1;
          data_d  = bus.i_data;
          sof_d   = bus.i_sof;
          par_d   = lfsr_nxt;
          if (bus.i_last || (cnt_q == CW'(K_DATA - 1))) begin
            state_d = S_PARITY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        valid_d = 1'b1;
        parf_d  = 1'b1;
        data_d  = par_q[N_PARITY-1];
        par_d   = {par_q[N_PARITY-2:0], 8'h00};
        if (pcnt_q == PW'(N_PARITY - 1)) begin
          last_d  = 1'b1;
          pcnt_d  = '0;
          state_d = S_IDLE;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d != S_PARITY);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      par_q   <= '0;
      ready_q <= 1'b1;
      sof_q   <= 1'b0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      parf_q  <= 1'b0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      par_q   <= par_d;
      ready_q <= ready_d;
      sof_q   <= sof_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      parf_q  <= parf_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.o_ready = ready_q;
  assign bus.o_sof   = sof_q;
  assign bus.o_data  = data_q;
  assign bus.o_valid = valid_q;
  assign bus.o_par   = parf_q;
  assign bus.o_last  = last_q;
  assign bus.o_ovf   = ovf_q;

endmodule

// File: tb/tb_tx_rs_enc_lfsr.sv
// Directed bench: small RS(6,4) instance with hand-computed parity, default RS(255,239) checked by syndromes.
module tb_tx_rs_enc_lfsr;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   rlow_b;

  logic [10:0] qa[$];
  logic [10:0] qb[$];
  logic [10:0] t3[$];

  tx_rs_enc_lfsr_if ifa ();
  tx_rs_enc_lfsr_if ifb ();

  tx_rs_enc_lfsr #(.N_PARITY(2), .K_DATA(4), .PRIM_POLY(9'h11D), .FCR(0)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .bus(ifa.slave)
  );
  tx_rs_enc_lfsr dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .bus(ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Entry layout: {sof, par, last, data}
  always @(negedge clk) begin
    if (ifa.o_valid) qa.push_back({ifa.o_sof, ifa.o_par, ifa.o_last, ifa.o_data});
    if (ifb.o_valid) qb.push_back({ifb.o_sof, ifb.o_par, ifb.o_last, ifb.o_data});
    if (!ifb.o_ready) rlow_b++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({8'h00, a} << i);
    for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (16'h011D << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] apow(input int e);
    logic [7:0] x;
    x = 8'h01;
    for (int i = 0; i < e; i++) x = gmul(x, 8'h02);
    return x;
  endfunction

  task automatic drv_a(input logic v, input logic [7:0] d, input logic l, input logic s, input logic en);
    ifa.i_valid = v; ifa.i_data = d; ifa.i_last = l; ifa.i_sof = s; ifa.i_rs_en = en;
    @(posedge clk); #1;
  endtask

  task automatic drv_b(input logic v, input logic [7:0] d, input logic l, input logic s, input logic en);
    ifb.i_valid = v; ifb.i_data = d; ifb.i_last = l; ifb.i_sof = s; ifb.i_rs_en = en;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    ifa.i_valid = 1'b0; ifa.i_last = 1'b0; ifa.i_sof = 1'b0;
    ifb.i_valid = 1'b0; ifb.i_last = 1'b0; ifb.i_sof = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_a"}, {ifa.o_ready, ifa.o_valid, ifa.o_sof, ifa.o_par, ifa.o_last, ifa.o_ovf, ifa.o_data}, 14'h2000);
    check({tag, "_b"}, {ifb.o_ready, ifb.o_valid, ifb.o_sof, ifb.o_par, ifb.o_last, ifb.o_ovf, ifb.o_data}, 14'h2000);
  endtask

  initial begin
    logic [10:0] exp6 [6];
    logic [7:0]  s;
    logic [7:0]  d;
    int          n;

    tests = 0; fails = 0; rlow_b = 0;
    rst_n = 1'b0;
    ifa.i_valid = 0; ifa.i_data = 0; ifa.i_last = 0; ifa.i_sof = 0; ifa.i_rs_en = 0;
    ifb.i_valid = 0; ifb.i_data = 0; ifb.i_last = 0; ifb.i_sof = 0; ifb.i_rs_en = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst_n = 1'b1;
    idle(2);

    // Test 1: g(x) = x^2 + 03x + 02, input 00 00 00 01 with last on the 4th symbol
    exp6[0] = {3'b100, 8'h00}; exp6[1] = {3'b000, 8'h00}; exp6[2] = {3'b000, 8'h00};
    exp6[3] = {3'b000, 8'h01}; exp6[4] = {3'b010, 8'h03}; exp6[5] = {3'b011, 8'h02};
    qa.delete();
    drv_a(1, 8'h00, 0, 1, 1);
    drv_a(1, 8'h00, 0, 0, 1);
    drv_a(1, 8'h00, 0, 0, 1);
    drv_a(1, 8'h01, 1, 0, 1);
    idle(6);
    check("t1_len", qa.size(), 6);
    for (int i = 0; i < 6 && i < qa.size(); i++) check("t1_sym", qa[i], exp6[i]);

    // Same data without i_last: forced end at K_DATA symbols gives the identical codeword
    qa.delete();
    drv_a(1, 8'h00, 0, 1, 1);
    drv_a(1, 8'h00, 0, 0, 1);
    drv_a(1, 8'h00, 0, 0, 1);
    drv_a(1, 8'h01, 0, 0, 1);
    idle(6);
    check("t1_forced_len", qa.size(), 6);
    for (int i = 0; i < 6 && i < qa.size(); i++) check("t1_forced_sym", qa[i], exp6[i]);

    // Single symbol 05: parity 05*03=0F, 05*02=0A
    qa.delete();
    drv_a(1, 8'h05, 1, 1, 1);
    idle(5);
    check("t1_short_len", qa.size(), 3);
    if (qa.size() == 3) begin
      check("t1_short_d", qa[0], {3'b100, 8'h05});
      check("t1_short_p1", qa[1], {3'b010, 8'h0F});
      check("t1_short_p0", qa[2], {3'b011, 8'h0A});
    end

    // Test 2: 239 zero symbols, forced end
    qb.delete();
    rlow_b = 0;
    for (int i = 0; i < 239; i++) drv_b(1, 8'h00, 0, (i == 0), 1);
    idle(22);
    check("t2_len", qb.size(), 255);
    check("t2_rdy_low", rlow_b, 16);
    if (qb.size() == 255) begin
      n = 0;
      for (int i = 0; i < 255; i++) if (qb[i][7:0] == 8'h00) n++;
      check("t2_zero_syms", n, 255);
      check("t2_last_data", qb[238][10:8], 3'b000);
      check("t2_first_par", qb[239][10:8], 3'b010);
      check("t2_final_par", qb[254][10:8], 3'b011);
    end

    // Test 3: single 01 gives parity = g; codeword must vanish at a^0..a^15
    qb.delete();
    drv_b(1, 8'h01, 1, 1, 1);
    idle(22);
    check("t3_len", qb.size(), 17);
    if (qb.size() == 17) begin
      check("t3_data", qb[0], {3'b100, 8'h01});
      check("t3_g0", qb[16], {3'b011, apow(120)});
      n = 0;
      for (int i = 1; i < 17; i++) if (qb[i][9]) n++;
      check("t3_par_cnt", n, 16);
      for (int r = 0; r < 16; r++) begin
        s = 8'h00;
        for (int k = 0; k < 17; k++) s = gmul(s, apow(r)) ^ qb[k][7:0];
        check("t3_syndrome", s, 8'h00);
      end
    end
    t3 = qb;

    // Test 4: bypass, AA..B3, one-cycle latency, o_ready never low
    qb.delete();
    rlow_b = 0;
    for (int i = 0; i < 10; i++) begin
      d = 8'(170 + i);
      drv_b(1, d, (i == 9), (i == 0), 0);
      check("t4_out", {ifb.o_valid, ifb.o_sof, ifb.o_par, ifb.o_last, ifb.o_data},
            {1'b1, (i == 0), 1'b0, (i == 9), d});
    end
    idle(3);
    check("t4_len", qb.size(), 10);
    check("t4_rdy_low", rlow_b, 0);

    // Test 5: i_rs_en toggled mid-DATA ignored; i_valid held through PARITY is dropped
    check("t5_ovf_pre", ifa.o_ovf, 1'b0);
    qa.delete();
    drv_a(1, 8'h00, 0, 1, 1);
    drv_a(1, 8'h00, 0, 0, 0);
    drv_a(1, 8'h00, 0, 0, 0);
    drv_a(1, 8'h01, 1, 0, 0);
    drv_a(1, 8'h55, 0, 0, 0);
    drv_a(1, 8'h55, 0, 0, 0);
    idle(4);
    check("t5_len", qa.size(), 6);
    for (int i = 0; i < 6 && i < qa.size(); i++) check("t5_sym", qa[i], exp6[i]);
    check("t5_ovf", ifa.o_ovf, 1'b1);

    // Test 6: reset in DATA after 5 symbols, then a fresh encode
    for (int i = 0; i < 5; i++) drv_b(1, 8'(17 + i), 0, (i == 0), 1);
    ifb.i_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    check_reset("t6_reset");
    idle(2);
    rst_n = 1'b1;
    idle(1);
    qb.delete();
    drv_b(1, 8'h01, 1, 1, 1);
    idle(22);
    check("t6_len", qb.size(), 17);
    if (qb.size() == 17 && t3.size() == 17)
      for (int i = 0; i < 17; i++) check("t6_sym", qb[i], t3[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
